// File: rtl/custom_busmatrix_wrr_arbiter.sv
// Weighted round-robin output-stage arbiter for the custom AHB bus matrix.
// Four input ports share one slave; per-port credits set the bandwidth ratio.

module custom_busmatrix_wrr_credit #(
  parameter int WEIGHT_W = 4
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                i_en,
  input  logic                i_refill,
  input  logic                i_consume,
  input  logic [WEIGHT_W-1:0] i_weight,
  output logic [WEIGHT_W-1:0] o_credit
);
  logic [WEIGHT_W-1:0] w_eff;
  logic [WEIGHT_W-1:0] r_credit;

  // A zero weight still earns one grant per refill.
  assign w_eff = (i_weight == '0) ? WEIGHT_W'(1) : i_weight;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_credit <= w_eff;
    end else if (i_en) begin
      if (i_refill)
        r_credit <= i_consume ? (w_eff - WEIGHT_W'(1)) : w_eff;
      else if (i_consume && (r_credit != '0))
        r_credit <= r_credit - WEIGHT_W'(1);
    end
  end

  assign o_credit = r_credit;
endmodule

module custom_busmatrix_wrr_arbiter #(
  parameter int WEIGHT_W = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [3:0]            req_port,
  input  logic [4*WEIGHT_W-1:0] weight_cfg,
  input  logic                  HREADYM,
  input  logic                  HSELM,
  input  logic [1:0]            HTRANSM,
  input  logic [2:0]            HBURSTM,
  input  logic                  HMASTLOCKM,
  output logic [1:0]            addr_in_port,
  output logic                  no_port,
  output logic [3:0]            credit_empty
);
  localparam logic [1:0] TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NSEQ = 2'b10, TR_SEQ = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'd0, BU_INCR = 3'd1, BU_WRAP4 = 3'd2, BU_INCR4 = 3'd3,
                         BU_WRAP8 = 3'd4, BU_INCR8 = 3'd5, BU_WRAP16 = 3'd6, BU_INCR16 = 3'd7;

  logic [3:0][WEIGHT_W-1:0] w_credit;
  logic [3:0]               w_elig;
  logic                     w_refill;
  logic                     w_consume;
  logic [3:0]               w_cur_oh;
  logic [1:0]               w_p1;
  logic [2:0]               w_pick_e0, w_pick_r0, w_pick_eo, w_pick_ro;

  logic [3:0] r_remain, w_next_remain;
  logic       r_hold, w_next_hold;
  logic [1:0] r_early, w_next_early;
  logic [1:0] r_port, w_next_port;
  logic       r_no_port, w_next_no_port;

  // Returns {found, index} of the first set bit scanning upward from start.
  function automatic logic [2:0] f_pick(input logic [3:0] v, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_consume = HSELM & ~r_no_port & (HTRANSM == TR_NSEQ);
  assign w_refill  = (|req_port) & ~(|w_elig);

  for (genvar i = 0; i < 4; i++) begin : g_port
    custom_busmatrix_wrr_credit #(.WEIGHT_W(WEIGHT_W)) u_credit (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .i_en      (HREADYM),
      .i_refill  (w_refill),
      .i_consume (w_consume && (r_port == 2'(i))),
      .i_weight  (weight_cfg[i*WEIGHT_W +: WEIGHT_W]),
      .o_credit  (w_credit[i])
    );
    assign credit_empty[i] = (w_credit[i] == '0);
    assign w_elig[i]       = req_port[i] & ~credit_empty[i];
  end

  assign w_cur_oh  = 4'b0001 << r_port;
  assign w_p1      = r_port + 2'd1;
  assign w_pick_e0 = f_pick(w_elig, 2'd0);
  assign w_pick_r0 = f_pick(req_port, 2'd0);
  assign w_pick_eo = f_pick(w_elig & ~w_cur_oh, w_p1);
  assign w_pick_ro = f_pick(req_port & ~w_cur_oh, w_p1);

  // Burst tracker: keeps fixed bursts whole, caps chained short INCR bursts.
  always_comb begin
    w_next_remain = r_remain;
    w_next_hold   = r_hold;
    if (!HSELM || HTRANSM == TR_IDLE) begin
      w_next_remain = 4'd0;
      w_next_hold   = 1'b0;
    end else begin
      case (HTRANSM)
        TR_NSEQ: begin
          case (HBURSTM)
            BU_INCR16, BU_WRAP16: begin w_next_remain = 4'd14; w_next_hold = 1'b1; end
            BU_INCR8,  BU_WRAP8:  begin w_next_remain = 4'd6;  w_next_hold = 1'b1; end
            BU_INCR4,  BU_WRAP4:  begin w_next_remain = 4'd2;  w_next_hold = 1'b1; end
            BU_INCR: begin
              w_next_remain = (r_early == 2'd1) ? 4'd0 : 4'd2;
              w_next_hold   = (r_early != 2'd1);
            end
            default: begin w_next_remain = 4'd0; w_next_hold = 1'b0; end
          endcase
        end
        TR_SEQ: begin
          if (r_remain == 4'd0) w_next_hold = 1'b0;
          else                  w_next_remain = r_remain - 4'd1;
        end
        default: ;
      endcase
    end
    if (!w_next_hold)              w_next_early = 2'd0;
    else if (HTRANSM == TR_NSEQ)   w_next_early = r_early + 2'd1;
    else                           w_next_early = r_early;
  end

  always_comb begin
    w_next_port    = r_port;
    w_next_no_port = r_no_port;
    if (HMASTLOCKM || w_next_hold) begin
      w_next_no_port = 1'b0;
    end else if (r_no_port) begin
      if (w_pick_e0[2]) begin
        w_next_port    = w_pick_e0[1:0];
        w_next_no_port = 1'b0;
      end else if (w_pick_r0[2]) begin
        w_next_port    = w_pick_r0[1:0];
        w_next_no_port = 1'b0;
      end
    end else if (w_pick_eo[2]) begin
      w_next_port = w_pick_eo[1:0];
    end else if (w_elig[r_port] || HSELM) begin
      w_next_port = r_port;
    end else if (w_pick_ro[2]) begin
      w_next_port = w_pick_ro[1:0];
    end else begin
      w_next_no_port = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_remain  <= 4'd0;
      r_hold    <= 1'b0;
      r_early   <= 2'd0;
      r_port    <= 2'd0;
      r_no_port <= 1'b1;
    end else if (HREADYM) begin
      r_remain  <= w_next_remain;
      r_hold    <= w_next_hold;
      r_early   <= w_next_early;
      r_port    <= w_next_port;
      r_no_port <= w_next_no_port;
    end
  end

  assign addr_in_port = r_port;
  assign no_port      = r_no_port;
endmodule

// File: tb/tb_custom_busmatrix_wrr_arbiter.sv
// Directed bench for the weighted round-robin output arbiter.
module tb_custom_busmatrix_wrr_arbiter;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [3:0]  req_port;
  logic [15:0] weight_cfg;
  logic        HREADYM, HSELM, HMASTLOCKM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HBURSTM;
  logic [1:0]  addr_in_port;
  logic        no_port;
  logic [3:0]  credit_empty;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR8 = 3'd5;

  custom_busmatrix_wrr_arbiter #(.WEIGHT_W(4)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_port     (req_port),
    .weight_cfg   (weight_cfg),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .credit_empty (credit_empty)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus(input logic sel, input logic [1:0] tr, input logic [2:0] bu);
    HSELM   = sel;
    HTRANSM = tr;
    HBURSTM = bu;
  endtask

  task automatic do_reset(input logic [15:0] w);
    weight_cfg = w;
    HRESET     = 1'b1;
    req_port   = 4'b0000;
    HREADYM    = 1'b1;
    HMASTLOCKM = 1'b0;
    bus(1'b0, IDLE, SINGLE);
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  // Expected selection after each transfer edge for weights p0=3, p1=1.
  logic [1:0] exp_wrr [16] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0,
                               2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
  logic [1:0] burst_tr [9] = '{NSEQ, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ};
  logic [1:0] burst_ad [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
  logic [3:0] wait_req [5] = '{4'b0100, 4'b0110, 4'b0000, 4'b1000, 4'b1110};

  initial begin
    int p1_grants;
    // 1: reset values and first grant
    weight_cfg = 16'h4444;
    HRESET = 1'b1; req_port = 4'b0000; HREADYM = 1'b1; HMASTLOCKM = 1'b0;
    bus(1'b0, IDLE, SINGLE);
    tick();
    chk("rst_no_port", no_port, 1'b1);
    chk("rst_addr", addr_in_port, 2'd0);
    chk("rst_credit_empty", credit_empty, 4'b0000);
    tick();
    HRESET = 1'b0;
    req_port = 4'b0100;
    tick();
    chk("first_grant_addr", addr_in_port, 2'd2);
    chk("first_grant_no_port", no_port, 1'b0);

    // 2: weighted share 3:1
    do_reset(16'h1113);
    req_port = 4'b0011;
    tick();
    chk("wrr_start", addr_in_port, 2'd0);
    bus(1'b1, NSEQ, SINGLE);
    p1_grants = 0;
    for (int i = 0; i < 16; i++) begin
      if (addr_in_port == 2'd1) p1_grants++;
      tick();
      chk($sformatf("wrr_seq%0d", i), addr_in_port, exp_wrr[i]);
      if (i == 3) chk("wrr_drained", credit_empty, 4'b0011);
      if (i == 4) chk("wrr_refilled", credit_empty, 4'b0000);
    end
    chk("wrr_p1_share", p1_grants, 4);

    // 3: INCR8 burst hold with a BUSY beat
    do_reset(16'h4444);
    req_port = 4'b0010;
    tick();
    chk("burst_grant", addr_in_port, 2'd1);
    req_port = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      bus(1'b1, burst_tr[i], INCR8);
      tick();
      chk($sformatf("burst_beat%0d", i), addr_in_port, burst_ad[i]);
    end

    // 4: chained short INCR bursts give way
    do_reset(16'h4444);
    req_port = 4'b0001;
    tick();
    req_port = 4'b0101;
    bus(1'b1, NSEQ, INCR);
    tick();
    chk("incr_nseq1", addr_in_port, 2'd0);
    bus(1'b1, SEQ, INCR);
    tick();
    chk("incr_seq1", addr_in_port, 2'd0);
    bus(1'b1, NSEQ, INCR);
    tick();
    chk("incr_nseq2_switch", addr_in_port, 2'd2);

    // 5: wait states freeze everything, then lock holds the port
    do_reset(16'h4444);
    req_port = 4'b0001;
    tick();
    HREADYM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_port = wait_req[i];
      bus(i[0], NSEQ, SINGLE);
      tick();
      chk($sformatf("wait%0d_addr", i), addr_in_port, 2'd0);
      chk($sformatf("wait%0d_no_port", i), no_port, 1'b0);
      chk($sformatf("wait%0d_credit", i), credit_empty, 4'b0000);
    end
    HREADYM = 1'b1;
    HMASTLOCKM = 1'b1;
    req_port = 4'b0101;
    bus(1'b1, NSEQ, SINGLE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lock%0d", i), addr_in_port, 2'd0);
    end
    HMASTLOCKM = 1'b0;
    bus(1'b0, IDLE, SINGLE);
    tick();
    chk("unlock_switch", addr_in_port, 2'd2);
    HREADYM = 1'b0;
    HRESET = 1'b1;
    tick();
    chk("midrst_addr", addr_in_port, 2'd0);
    chk("midrst_no_port", no_port, 1'b1);
    HRESET = 1'b0;
    HREADYM = 1'b1;

    // 6: zero weight and refill coinciding with consume
    do_reset(16'h0111);
    chk("zw_reset_credit", credit_empty, 4'b0000);
    req_port = 4'b0001;
    tick();
    req_port = 4'b1001;
    bus(1'b1, NSEQ, SINGLE);
    tick();
    chk("zw_to_p3", addr_in_port, 2'd3);
    chk("zw_p0_empty", credit_empty, 4'b0001);
    req_port = 4'b1000;
    tick();
    chk("zw_p3_consumed", credit_empty, 4'b1001);
    tick();
    chk("zw_coincident", credit_empty, 4'b1000);
    chk("zw_keep_p3", addr_in_port, 2'd3);
    bus(1'b0, IDLE, SINGLE);
    tick();
    chk("zw_release", no_port, 1'b1);
    chk("zw_refill_idle", credit_empty, 4'b0000);
    tick();
    chk("zw_regrant", addr_in_port, 2'd3);
    chk("zw_regrant_np", no_port, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
